// File: rtl/encoder_4to2_priority_filtered_if.sv
// Request/enable lines into the encoder and the filtered code, valid and change strobe out.
// The master side drives requests; the slave side is the encoder.
interface encoder_4to2_priority_filtered_if;
  logic e;
  logic y0;
  logic y1;
  logic y2;
  logic y3;
  logic a;
  logic b;
  logic v;
  logic chg;

  modport master (
    output e, y0, y1, y2, y3,
    input  a, b, v, chg
  );

  modport slave (
    input  e, y0, y1, y2, y3,
    output a, b, v, chg
  );
endinterface

// File: rtl/encoder_4to2_priority_filtered.sv
// Registered 4-to-2 priority encoder with enable and a FILTER-sample stability filter.
// Outputs update FILTER cycles after the candidate settles; no backpressure, strobe-only output.
module encoder_4to2_priority_filtered #(
  parameter int FILTER   = 1,
  parameter bit PRIO_LOW = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  encoder_4to2_priority_filtered_if.slave   bus
);

  localparam int CW = $clog2(FILTER + 1);

  if (FILTER < 1 || FILTER > 15) begin : g_bad_filter
    $error("FILTER must be in 1..15");
  end

  typedef struct packed {
    logic v;
    logic a;
    logic b;
  } code_t;

  code_t          cand;
  code_t          cand_reg;
  code_t          out_reg;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic           chg_reg;
  logic           upd;

  always_comb begin
    cand = '0;
    if (bus.e) begin
      if (PRIO_LOW) begin
        if      (bus.y0) cand = 3'b100;
        else if (bus.y1) cand = 3'b101;
        else if (bus.y2) cand = 3'b110;
        else if (bus.y3) cand = 3'b111;
      end else begin
        if      (bus.y3) cand = 3'b111;
        else if (bus.y2) cand = 3'b110;
        else if (bus.y1) cand = 3'b101;
        else if (bus.y0) cand = 3'b100;
      end
    end
  end

  // Count saturates at FILTER so a long-stable input never re-triggers an update.
  always_comb begin
    cnt_nxt = CW'(1);
    if (cand == cand_reg) begin
      if (cnt >= CW'(FILTER)) cnt_nxt = CW'(FILTER);
      else                    cnt_nxt = cnt + CW'(1);
    end
  end

  assign upd = (cnt_nxt == CW'(FILTER)) && (cand != out_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_reg <= '0;
      cnt      <= '0;
      out_reg  <= '0;
      chg_reg  <= 1'b0;
    end else begin
      cand_reg <= cand;
      cnt      <= cnt_nxt;
      chg_reg  <= upd;
      if (upd) out_reg <= cand;
    end
  end

  assign bus.v   = out_reg.v;
  assign bus.a   = out_reg.a;
  assign bus.b   = out_reg.b;
  assign bus.chg = chg_reg;

endmodule

// File: tb/tb_encoder_4to2_priority_filtered.sv
// Scoreboard bench for the filtered priority encoder: three instances cover FILTER/PRIO_LOW settings.
module tb_encoder_4to2_priority_filtered;

  typedef struct {
    logic [2:0] vab;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst0;
  logic rst1;
  logic rst2;
  int   edge_cnt;
  int   n_chk;
  int   n_fail;
  exp_t q[3][$];

  encoder_4to2_priority_filtered_if if0 ();
  encoder_4to2_priority_filtered_if if1 ();
  encoder_4to2_priority_filtered_if if2 ();

  encoder_4to2_priority_filtered #(.FILTER(1), .PRIO_LOW(1'b0)) u0 (.clk(clk), .rst(rst0), .bus(if0));
  encoder_4to2_priority_filtered #(.FILTER(1), .PRIO_LOW(1'b1)) u1 (.clk(clk), .rst(rst1), .bus(if1));
  encoder_4to2_priority_filtered #(.FILTER(3), .PRIO_LOW(1'b0)) u2 (.clk(clk), .rst(rst2), .bus(if2));

  logic [2:0] vab_w [3];
  logic       chg_w [3];

  assign vab_w[0] = {if0.v, if0.a, if0.b};
  assign vab_w[1] = {if1.v, if1.a, if1.b};
  assign vab_w[2] = {if2.v, if2.a, if2.b};
  assign chg_w[0] = if0.chg;
  assign chg_w[1] = if1.chg;
  assign chg_w[2] = if2.chg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h required %0h (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  task automatic push(input int id, input logic [2:0] vab, input int dly);
    exp_t e;
    e.vab = vab;
    e.cyc = edge_cnt + dly;
    q[id].push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set0(input logic e, input logic [3:0] y);
    if0.e = e; if0.y3 = y[3]; if0.y2 = y[2]; if0.y1 = y[1]; if0.y0 = y[0];
  endtask

  task automatic set1(input logic e, input logic [3:0] y);
    if1.e = e; if1.y3 = y[3]; if1.y2 = y[2]; if1.y1 = y[1]; if1.y0 = y[0];
  endtask

  task automatic set2(input logic e, input logic [3:0] y);
    if2.e = e; if2.y3 = y[3]; if2.y2 = y[2]; if2.y1 = y[1]; if2.y0 = y[0];
  endtask

  // Every chg pulse must match the next queued update in both value and edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (chg_w[i] === 1'b1) begin
        if (q[i].size() == 0) begin
          n_chk  = n_chk + 1;
          n_fail = n_fail + 1;
          $display("FAIL unexpected_chg inst %0d: got vab=%b at edge %0d, required no pulse", i, vab_w[i], edge_cnt);
        end else begin
          exp_t e;
          e = q[i].pop_front();
          check($sformatf("chg_vab inst %0d", i), int'(vab_w[i]), int'(e.vab));
          check($sformatf("chg_edge inst %0d", i), edge_cnt, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [3:0] y;
    n_chk  = 0;
    n_fail = 0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    set0(1'b0, 4'b0000);
    set1(1'b0, 4'b0000);
    set2(1'b0, 4'b0000);
    tick(3);
    check("reset inst0", int'({vab_w[0], chg_w[0]}), 0);
    check("reset inst1", int'({vab_w[1], chg_w[1]}), 0);
    check("reset inst2", int'({vab_w[2], chg_w[2]}), 0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    tick(2);
    check("idle_after_reset inst2", int'({vab_w[2], chg_w[2]}), 0);

    // One-hot walk, FILTER=1, y3 highest
    set0(1'b1, 4'b0001); push(0, 3'b100, 1); tick(10);
    check("onehot y0", int'(vab_w[0]), 4);
    set0(1'b1, 4'b0010); push(0, 3'b101, 1); tick(10);
    set0(1'b1, 4'b0100); push(0, 3'b110, 1); tick(10);
    set0(1'b1, 4'b1000); push(0, 3'b111, 1); tick(10);
    check("onehot y3", int'(vab_w[0]), 7);
    set0(1'b0, 4'b1000); push(0, 3'b000, 1); tick(10);
    check("enable_low", int'(vab_w[0]), 0);

    // Priority resolution
    set0(1'b1, 4'b1111); push(0, 3'b111, 1); tick(5);
    check("prio_high all", int'(vab_w[0]), 7);
    set0(1'b1, 4'b0011); push(0, 3'b101, 1); tick(5);
    check("prio_high y1y0", int'(vab_w[0]), 5);
    set1(1'b1, 4'b1111); push(1, 3'b100, 1); tick(5);
    check("prio_low all", int'(vab_w[1]), 4);
    set1(1'b1, 4'b1110); push(1, 3'b101, 1); tick(5);
    check("prio_low y3y2y1", int'(vab_w[1]), 5);

    // Loopback through a 2-to-4 decoder model
    for (int c = 0; c < 4; c++) begin
      y = 4'b0001 << c;
      set0(1'b1, y);
      push(0, {1'b1, 2'(c)}, 1);
      tick(5);
      check($sformatf("loopback code %0d", c), int'(vab_w[0]), 4 + c);
    end

    // FILTER=3 settle and long hold
    set2(1'b1, 4'b0100); push(2, 3'b110, 3); tick(23);
    check("filter_hold", int'(vab_w[2]), 6);

    // Two-cycle glitch must be rejected
    set2(1'b1, 4'b1100); tick(2);
    set2(1'b1, 4'b0100); tick(5);
    check("glitch_reject", int'(vab_w[2]), 6);

    set2(1'b1, 4'b1100); push(2, 3'b111, 3); tick(6);
    check("filter_y3", int'(vab_w[2]), 7);

    // Short enable drop keeps v asserted
    set2(1'b0, 4'b1100); tick(2);
    check("e_drop mid", int'(vab_w[2]), 7);
    set2(1'b1, 4'b1100); tick(5);
    check("e_drop after", int'(vab_w[2]), 7);

    // Reset with count at 2 toward a new code
    set2(1'b1, 4'b0010); tick(2);
    rst2 = 1'b1; tick(1);
    check("mid_reset", int'({vab_w[2], chg_w[2]}), 0);
    rst2 = 1'b0;
    push(2, 3'b101, 3);
    tick(2);
    check("post_reset counting", int'(vab_w[2]), 0);
    tick(4);
    check("post_reset settled", int'(vab_w[2]), 5);

    tick(5);
    for (int i = 0; i < 3; i++)
      check($sformatf("pending_updates inst %0d", i), q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_4to2_priority_filtered.md
Name: encoder_4to2_priority_filtered

Overview:
- Registered 4-to-2 priority encoder with enable. It is the inverse of the team's 2-to-4 decoder with enable.
- Takes four request lines y0..y3 and produces a 2-bit code (a = MSB, b = LSB), a valid flag and a one-cycle change strobe.
- An optional stability filter requires a code to hold for FILTER consecutive samples before the outputs update. This rejects single-cycle glitches on the request lines.
- Sits between raw request/status lines and downstream logic. The code can be fed straight back into the decoder for loopback checks.

Parameters:
- FILTER, 1: number of consecutive identical samples required before the outputs update. Legal range is 1 to 15. FILTER=1 means the outputs follow the inputs with a latency of 1 cycle.
- PRIO_LOW, 0: priority order. 0 means y3 has the highest priority. 1 means y0 has the highest priority.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- e  input  1  enable. When low, the encoder reports "no valid request".
- y0  input  1  request line 0 (code 00).
- y1  input  1  request line 1 (code 01).
- y2  input  1  request line 2 (code 10).
- y3  input  1  request line 3 (code 11).
- a  output  1  code MSB, registered.
- b  output  1  code LSB, registered.
- v  output  1  valid: an enabled request is present in the registered code.
- chg  output  1  one-cycle pulse when {v,a,b} updates to a different value.

Behaviour:
- Reset (rst=1 at a clk edge): a=0, b=0, v=0, chg=0. Internal candidate register = 000 and counter = 0. Reset overrides all other activity, including a filter count in progress.
- Combinational candidate {vc,ac,bc} is formed each cycle:
  - If e=0: 000.
  - If e=1 and no y asserted: 000.
  - If e=1 with PRIO_LOW=0: the highest asserted line wins, checked in order y3, y2, y1, y0. y3 gives 1_11, y2 gives 1_10, y1 gives 1_01, y0 gives 1_00.
  - If e=1 with PRIO_LOW=1: checked in order y0, y1, y2, y3, with the same codes.
  - v=1 with code 00 means y0; v=0 with code 00 means no request. These two cases are distinguished only by v.
- Filter counter, counter width = clog2(FILTER+1). At each non-reset edge:
  - n = (candidate == cand_reg) ? min(cnt+1, FILTER) : 1.
  - cand_reg <= candidate; cnt <= n.
- Output update, at each non-reset edge:
  - If n == FILTER and candidate != {v,a,b}: {v,a,b} <= candidate and chg <= 1.
  - Otherwise {v,a,b} hold and chg <= 0.
- Latency:
  - FILTER=1: outputs reflect inputs sampled at edge k immediately after edge k.
  - FILTER=N: the candidate must be identical at edges k through k+N-1; the outputs update at edge k+N-1.
- The counter saturates at FILTER. A long-stable input never wraps the counter and never re-pulses chg.
- Glitches: a candidate change shorter than FILTER samples restarts the count and never reaches the outputs. The outputs retain the last filtered value.
- The enable passes through the same filter as the y lines. Dropping e for fewer than FILTER cycles leaves v=1.
- chg is high for exactly one cycle per output update. It never asserts in the cycle after reset unless the first filtered candidate differs from 000.
- Simultaneous requests resolve by priority only. Releasing a higher-priority line exposes the next lower asserted one, subject to the filter.

Test Plan:
- FILTER=1, PRIO_LOW=0: reset, then e=1 with y0..y3 one-hot in turn, 10 cycles each.
  - Required response: {v,a,b} = 100, 101, 110, 111, each visible after 1 clk, with chg pulsing once per step.
  - Then e=0 with y3=1: required {v,a,b}=000 after 1 clk, with one chg pulse.
- Priority check: e=1, y0..y3 = 1111.
  - PRIO_LOW=0: required {v,a,b}=111.
  - PRIO_LOW=1: required {v,a,b}=100.
  - Then y3=0 and y2=0 with PRIO_LOW=0: required 101.
- FILTER=3: e=1, y2=1 held.
  - Required: outputs update on the 3rd sampling edge to 110, with a single chg pulse, then hold with chg=0 for 20 cycles.
- FILTER=3 glitch: from a stable 110, pulse y3 high for 2 cycles.
  - Required: outputs stay 110 and chg stays 0.
  - Then hold y3 for 3 cycles: required 111 with one chg pulse.
- Reset mid-operation: FILTER=3 with the count at 2 toward a new code, assert rst for 1 cycle.
  - Required: a=b=v=chg=0 the next cycle, and a fresh 3-sample count is needed afterwards.
- Loopback: drive the 2-to-4 decoder with e=1 and each value of {a,b}, and feed its y outputs into this block.
  - Required: recovered {a,b} equals the driven {a,b} with v=1, for all 4 codes.
